// File: rtl/seq_addsub_acc_pkg.sv
// ============================================================================
// Module  : seq_addsub_acc_pkg
// Brief   : Lab arithmetic package: operation mode and sequencer state enums.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_addsub_acc_pkg;

  typedef enum logic [1:0] {
    MODE_ADD    = 2'b00,
    MODE_SUB    = 2'b01,
    MODE_ACC    = 2'b10,
    MODE_ACCSUB = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_addsub_acc_chunk_adder.sv
// ============================================================================
// Module  : chunk_adder (with fulladder cell)
// Brief   : CHUNK-bit ripple adder built from fulladder cells; also exposes
//           the carry into its MSB for signed-overflow detection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] A,
  input  logic [CHUNK-1:0] B,
  input  logic             Ci,
  output logic [CHUNK-1:0] S,
  output logic             Co,
  output logic             Cmsb
);
  logic [CHUNK:0] w_c;

  assign w_c[0] = Ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    fulladder u_fa (
      .a (A[i]),
      .b (B[i]),
      .ci(w_c[i]),
      .s (S[i]),
      .co(w_c[i+1])
    );
  end

  assign Co   = w_c[CHUNK];
  assign Cmsb = w_c[CHUNK-1];
endmodule

`default_nettype wire

// File: rtl/seq_addsub_acc.sv
// ============================================================================
// Module  : seq_addsub_acc
// Brief   : Multi-cycle add/sub/accumulate unit, CHUNK bits per clock through
//           one shared ripple stage, start/done handshake, registered flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_addsub_acc
  import seq_addsub_acc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             Ovf
);
  localparam int c_NCH = WIDTH / CHUNK;
  localparam int c_KW  = (c_NCH > 1) ? $clog2(c_NCH) : 1;
  localparam logic [c_KW-1:0] c_K_LAST = c_KW'(c_NCH - 1);

  state_e            r_state;
  state_e            w_next;
  logic [c_KW-1:0]   r_k;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_c;
  logic [WIDTH-1:0]  r_part;
  logic [WIDTH-1:0]  r_s;
  logic              r_co;
  logic              r_ovf;

  logic [WIDTH-1:0]  w_lat_a;
  logic [WIDTH-1:0]  w_lat_b;
  logic              w_lat_c;
  logic [CHUNK-1:0]  w_a_chunk;
  logic [CHUNK-1:0]  w_b_chunk;
  logic [CHUNK-1:0]  w_sum;
  logic              w_cout;
  logic              w_cmsb;
  logic [WIDTH-1:0]  w_part_next;
  logic              w_last;

  // Subtraction is A + ~B + 1; accumulate modes take the current result as A.
  always_comb begin
    w_lat_a = X;
    w_lat_b = Y;
    w_lat_c = 1'b0;
    case (mode_e'(Mode))
      MODE_ADD: ;
      MODE_SUB: begin
        w_lat_b = ~Y;
        w_lat_c = 1'b1;
      end
      MODE_ACC: begin
        w_lat_a = r_s;
        w_lat_b = X;
      end
      MODE_ACCSUB: begin
        w_lat_a = r_s;
        w_lat_b = ~X;
        w_lat_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_a_chunk = r_a[r_k*CHUNK +: CHUNK];
  assign w_b_chunk = r_b[r_k*CHUNK +: CHUNK];
  assign w_last    = (r_k == c_K_LAST);

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .A   (w_a_chunk),
    .B   (w_b_chunk),
    .Ci  (r_c),
    .S   (w_sum),
    .Co  (w_cout),
    .Cmsb(w_cmsb)
  );

  always_comb begin
    w_part_next = r_part;
    w_part_next[r_k*CHUNK +: CHUNK] = w_sum;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (Start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Result registers load on the last RUN edge so they are valid with Done.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_k    <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_part <= '0;
      r_s    <= '0;
      r_co   <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (Start) begin
          r_a <= w_lat_a;
          r_b <= w_lat_b;
          r_c <= w_lat_c;
          r_k <= '0;
        end
        RUN: begin
          r_part <= w_part_next;
          r_c    <= w_cout;
          if (w_last) begin
            r_k   <= '0;
            r_s   <= w_part_next;
            r_co  <= w_cout;
            r_ovf <= w_cmsb ^ w_cout;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy = (r_state == RUN);
  assign Done = (r_state == DONE);
  assign S    = r_s;
  assign Co   = r_co;
  assign Ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_seq_addsub_acc.sv
// ============================================================================
// Module  : tb_seq_addsub_acc
// Brief   : Directed-vector bench for seq_addsub_acc (CHUNK=4) plus random
//           sweeps of CHUNK=1 and CHUNK=16 instances against a reference.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_addsub_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] x, y;
  logic        busy, done, co, ovf;
  logic [15:0] s;

  logic        sw_start [2];
  logic [1:0]  sw_mode  [2];
  logic [15:0] sw_x     [2];
  logic [15:0] sw_y     [2];
  logic        sw_busy  [2];
  logic        sw_done  [2];
  logic [15:0] sw_s     [2];
  logic        sw_co    [2];
  logic        sw_ovf   [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_addsub_acc #(.WIDTH(16), .CHUNK(4)) dut (
    .Clock(clk), .Reset(rst), .Start(start), .Mode(mode), .X(x), .Y(y),
    .Busy(busy), .Done(done), .S(s), .Co(co), .Ovf(ovf)
  );

  seq_addsub_acc #(.WIDTH(16), .CHUNK(1)) dut_c1 (
    .Clock(clk), .Reset(rst), .Start(sw_start[0]), .Mode(sw_mode[0]),
    .X(sw_x[0]), .Y(sw_y[0]), .Busy(sw_busy[0]), .Done(sw_done[0]),
    .S(sw_s[0]), .Co(sw_co[0]), .Ovf(sw_ovf[0])
  );

  seq_addsub_acc #(.WIDTH(16), .CHUNK(16)) dut_c16 (
    .Clock(clk), .Reset(rst), .Start(sw_start[1]), .Mode(sw_mode[1]),
    .X(sw_x[1]), .Y(sw_y[1]), .Busy(sw_busy[1]), .Done(sw_done[1]),
    .S(sw_s[1]), .Co(sw_co[1]), .Ovf(sw_ovf[1])
  );

  // Reference: returns {co, ovf, s}; subtract borrow judged by magnitude.
  function automatic logic [17:0] ref_op(input logic [1:0] m, input logic [15:0] acc,
                                         input logic [15:0] xv, input logic [15:0] yv);
    logic [15:0] a, b, r;
    logic [16:0] full;
    logic        c, v;
    a = m[1] ? acc : xv;
    b = m[1] ? xv  : yv;
    if (m[0]) begin
      r = a - b;
      c = (a >= b);
      v = (a[15] != b[15]) && (r[15] != a[15]);
    end else begin
      full = {1'b0, a} + {1'b0, b};
      r = full[15:0];
      c = full[16];
      v = (a[15] == b[15]) && (r[15] != a[15]);
    end
    return {c, v, r};
  endfunction

  // Launch one op on the CHUNK=4 instance; returns at the negedge after Done.
  task automatic run_main(input logic [1:0] m, input logic [15:0] xv, input logic [15:0] yv,
                          output int bcnt, output int done_at);
    int cyc;
    bit got;
    bcnt = 0; done_at = 0; cyc = 0; got = 0;
    start = 1'b1; mode = m; x = xv; y = yv;
    @(negedge clk);
    start = 1'b0; x = 16'hDEAD; y = 16'hBEEF; mode = ~m;
    while (!got && cyc < 40) begin
      if (done) begin
        got = 1; done_at = cyc + 1;
      end else begin
        if (busy) bcnt++;
        cyc++;
        @(negedge clk);
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL run_main_timeout: no Done within %0d cycles (mode=%0d)", cyc, m);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 2'b00; x = '0; y = '0;
    for (int i = 0; i < 2; i++) begin
      sw_start[i] = 1'b0; sw_mode[i] = 2'b00; sw_x[i] = '0; sw_y[i] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, s, co, ovf} !== 19'd0) begin
      bad++;
      $display("FAIL reset_hold: busy=%b done=%b s=%h co=%b ovf=%b, need all 0", busy, done, s, co, ovf);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, s, co, ovf} !== 19'd0) begin
      bad++;
      $display("FAIL reset_release: busy=%b done=%b s=%h co=%b ovf=%b, need all 0", busy, done, s, co, ovf);
    end
  endtask

  task automatic test_add_latency();
    int bc, da;
    run_main(2'b00, 16'h00FF, 16'h0001, bc, da);
    total++;
    if (bc !== 4) begin bad++; $display("FAIL add_busy_cycles: got %0d need 4", bc); end
    total++;
    if (da !== 5) begin bad++; $display("FAIL add_done_cycle: got %0d need 5", da); end
    total++;
    if ({s, co, ovf} !== {16'h0100, 1'b0, 1'b0}) begin
      bad++; $display("FAIL add_00ff: s=%h co=%b ovf=%b need s=0100 co=0 ovf=0", s, co, ovf);
    end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_pulse_width: done=%b after DONE, need 0", done); end
  endtask

  task automatic test_add_flags();
    int bc, da;
    run_main(2'b00, 16'hFFFF, 16'h0001, bc, da);
    total++;
    if ({s, co, ovf} !== {16'h0000, 1'b1, 1'b0}) begin
      bad++; $display("FAIL add_ffff: s=%h co=%b ovf=%b need s=0000 co=1 ovf=0", s, co, ovf);
    end
    run_main(2'b00, 16'h7FFF, 16'h0001, bc, da);
    total++;
    if ({s, co, ovf} !== {16'h8000, 1'b0, 1'b1}) begin
      bad++; $display("FAIL add_7fff: s=%h co=%b ovf=%b need s=8000 co=0 ovf=1", s, co, ovf);
    end
  endtask

  task automatic test_sub();
    int bc, da;
    run_main(2'b01, 16'h0005, 16'h0007, bc, da);
    total++;
    if ({s, co, ovf} !== {16'hFFFE, 1'b0, 1'b0}) begin
      bad++; $display("FAIL sub_5_7: s=%h co=%b ovf=%b need s=fffe co=0 ovf=0", s, co, ovf);
    end
    run_main(2'b01, 16'h8000, 16'h0001, bc, da);
    total++;
    if ({s, co, ovf} !== {16'h7FFF, 1'b1, 1'b1}) begin
      bad++; $display("FAIL sub_8000_1: s=%h co=%b ovf=%b need s=7fff co=1 ovf=1", s, co, ovf);
    end
  endtask

  task automatic test_acc();
    int bc, da;
    logic [15:0] exp_s [3];
    exp_s[0] = 16'h1234; exp_s[1] = 16'h2468; exp_s[2] = 16'h369C;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_main(2'b10, 16'h1234, 16'hFFFF, bc, da);
      total++;
      if (s !== exp_s[i]) begin
        bad++; $display("FAIL acc_step%0d: s=%h need %h", i, s, exp_s[i]);
      end
    end
    run_main(2'b11, 16'h369C, 16'h0000, bc, da);
    total++;
    if ({s, co, ovf} !== {16'h0000, 1'b1, 1'b0}) begin
      bad++; $display("FAIL accsub: s=%h co=%b ovf=%b need s=0000 co=1 ovf=0", s, co, ovf);
    end
  endtask

  task automatic test_back_to_back();
    int ndone, cyc;
    bit left_done;
    ndone = 0; cyc = 0; left_done = 0;
    start = 1'b1; mode = 2'b00; x = 16'h1111; y = 16'h2222;
    @(negedge clk);
    x = 16'hAAAA; y = 16'h5555; mode = 2'b01;
    // Start stays high through RUN and DONE; drop it once back in IDLE.
    while (!left_done && cyc < 40) begin
      if (done) ndone++;
      else if (ndone > 0) begin start = 1'b0; left_done = 1; end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    total++;
    if (ndone !== 1) begin bad++; $display("FAIL ignore_start_dones: got %0d need 1", ndone); end
    total++;
    if ({busy, s, co, ovf} !== {1'b0, 16'h3333, 1'b0, 1'b0}) begin
      bad++; $display("FAIL ignore_start_result: busy=%b s=%h co=%b ovf=%b need busy=0 s=3333 co=0 ovf=0", busy, s, co, ovf);
    end
  endtask

  task automatic test_reset_mid_run();
    int bc, da, ndone;
    ndone = 0;
    start = 1'b1; mode = 2'b00; x = 16'h0F0F; y = 16'h0101;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, s, co, ovf} !== 19'd0) begin
      bad++; $display("FAIL mid_run_reset: busy=%b done=%b s=%h co=%b ovf=%b need all 0", busy, done, s, co, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    total++;
    if (ndone !== 0) begin bad++; $display("FAIL mid_run_no_done: %0d busy/done cycles need 0", ndone); end
    run_main(2'b01, 16'h0010, 16'h0001, bc, da);
    total++;
    if ({s, co, ovf} !== {16'h000F, 1'b1, 1'b0}) begin
      bad++; $display("FAIL after_abort: s=%h co=%b ovf=%b need s=000f co=1 ovf=0", s, co, ovf);
    end
  endtask

  task automatic test_reset_with_start();
    int cyc;
    rst = 1'b1; start = 1'b1; mode = 2'b00; x = 16'h0001; y = 16'h0002;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_held_start: busy=%b need 0", busy); end
    rst = 1'b0;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL start_after_reset: busy=%b need 1", busy); end
    cyc = 0;
    while (!done && cyc < 20) begin cyc++; @(negedge clk); end
    @(negedge clk);
    total++;
    if (s !== 16'h0003) begin bad++; $display("FAIL start_after_reset_result: s=%h need 0003", s); end
  endtask

  task automatic test_sweep(input int idx, input int nch);
    logic [15:0] acc, xv, yv;
    logic [1:0]  m;
    logic [17:0] expv;
    int cyc, bcnt;
    bit got;
    acc = '0;
    for (int n = 0; n < 1000; n++) begin
      m  = 2'($urandom_range(0, 3));
      xv = 16'($urandom);
      yv = 16'($urandom);
      if (n % 7 == 0) xv = 16'h7FFF;
      if (n % 11 == 0) yv = 16'h8000;
      if (n % 13 == 0) xv = 16'hFFFF;
      expv = ref_op(m, acc, xv, yv);
      sw_start[idx] = 1'b1; sw_mode[idx] = m; sw_x[idx] = xv; sw_y[idx] = yv;
      @(negedge clk);
      sw_start[idx] = 1'b0; sw_x[idx] = ~xv; sw_y[idx] = ~yv; sw_mode[idx] = ~m;
      cyc = 0; bcnt = 0; got = 0;
      while (!got && cyc < nch + 8) begin
        if (sw_done[idx]) got = 1;
        else begin
          if (sw_busy[idx]) bcnt++;
          cyc++;
          @(negedge clk);
        end
      end
      total++;
      if (!got || bcnt != nch) begin
        bad++;
        $display("FAIL sweep_latency c%0d op%0d: got_done=%0d busy=%0d need busy=%0d", 16 / nch, n, got, bcnt, nch);
      end
      total++;
      if ({sw_co[idx], sw_ovf[idx], sw_s[idx]} !== expv) begin
        bad++;
        $display("FAIL sweep_result c%0d op%0d m=%0d x=%h y=%h acc=%h: s=%h co=%b ovf=%b need s=%h co=%b ovf=%b",
                 16 / nch, n, m, xv, yv, acc, sw_s[idx], sw_co[idx], sw_ovf[idx], expv[15:0], expv[17], expv[16]);
      end
      acc = expv[15:0];
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_add_latency();
    test_add_flags();
    test_sub();
    test_acc();
    test_back_to_back();
    test_reset_mid_run();
    test_reset_with_start();
    test_sweep(0, 16);
    test_sweep(1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
